// File: rtl/chess_pkg.sv
// chess_pkg: shared piece codes, board geometry, square index type and opening layout
package chess_pkg;
  localparam logic [3:0] EMPTY    = 4'd0;
  localparam logic [3:0] W_PAWN   = 4'd1;
  localparam logic [3:0] W_KNIGHT = 4'd2;
  localparam logic [3:0] W_BISHOP = 4'd3;
  localparam logic [3:0] W_ROOK   = 4'd4;
  localparam logic [3:0] W_QUEEN  = 4'd5;
  localparam logic [3:0] W_KING   = 4'd6;
  localparam logic [3:0] B_PAWN   = 4'd9;
  localparam logic [3:0] B_KNIGHT = 4'd10;
  localparam logic [3:0] B_BISHOP = 4'd11;
  localparam logic [3:0] B_ROOK   = 4'd12;
  localparam logic [3:0] B_QUEEN  = 4'd13;
  localparam logic [3:0] B_KING   = 4'd14;
  localparam int SQ_SIZE  = 55;
  localparam int BOARD_SQ = 8;
  typedef logic [5:0] sq_t;
  function automatic logic [3:0] back_rank(input logic [2:0] col, input logic black);
    return (col == 3'd0 || col == 3'd7) ? (black ? B_ROOK : W_ROOK) :
           (col == 3'd1 || col == 3'd6) ? (black ? B_KNIGHT : W_KNIGHT) :
           (col == 3'd2 || col == 3'd5) ? (black ? B_BISHOP : W_BISHOP) :
           (col == 3'd3) ? (black ? B_QUEEN : W_QUEEN) : (black ? B_KING : W_KING);
  endfunction
  function automatic logic [3:0] init_piece(input sq_t sq);
    return (sq[5:3] == 3'd0) ? back_rank(sq[2:0], 1'b1) :
           (sq[5:3] == 3'd1) ? B_PAWN :
           (sq[5:3] == 3'd6) ? W_PAWN :
           (sq[5:3] == 3'd7) ? back_rank(sq[2:0], 1'b0) : EMPTY;
  endfunction
endpackage

// File: rtl/board_state_ram.sv
// board_state_ram: 64-square piece store with two combinational reads and one write port with square clear
module board_state_ram
  import chess_pkg::*;
(
  input  logic       vga_clk,
  input  logic       reset,
  input  sq_t        pix_sq,
  output logic [3:0] pix_piece,
  input  sq_t        mv_sq,
  output logic [3:0] mv_piece,
  input  logic       wr_en,
  input  sq_t        wr_sq,
  input  logic [3:0] wr_piece,
  input  logic       clr_en,
  input  sq_t        clr_sq
);
  logic [3:0] mem [64];
  assign pix_piece = mem[pix_sq];
  assign mv_piece  = mem[mv_sq];
  // reset loads the opening layout; the write beats the clear so a same-square move keeps its piece
  always_ff @(posedge vga_clk)
    for (int i = 0; i < 64; i++)
      if (reset) mem[i] <= init_piece(sq_t'(i));
      else if (wr_en && wr_sq == sq_t'(i)) mem[i] <= wr_piece;
      else if (clr_en && clr_sq == sq_t'(i)) mem[i] <= EMPTY;
endmodule

// File: rtl/board_sprite_sel.sv
// board_sprite_sel: beam-to-square decode, sprite origin, registered pixel attributes and move handling
module board_sprite_sel
  import chess_pkg::*;
#(
  parameter int BOARD_X0     = 100,
  parameter int BOARD_Y0     = 20,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic [5:0] mv_from,
  input  logic [5:0] mv_to,
  input  logic [3:0] mv_promo,
  input  logic       wr_en,
  input  logic [5:0] wr_sq,
  input  logic [3:0] wr_piece,
  input  logic [5:0] cursor_sq,
  input  logic [5:0] sel_sq,
  input  logic       sel_valid,
  output logic [9:0] offsetX,
  output logic [9:0] offsetY,
  output logic [3:0] pix_piece,
  output logic       pix_square_on,
  output logic       pix_light,
  output logic       pix_cursor,
  output logic       pix_sel
);
  localparam int BOARD_PX = SQ_SIZE * BOARD_SQ;
  typedef enum logic [1:0] {IDLE, READ, WRITE} mv_state_t;
  mv_state_t state, state_nxt;
  logic [9:0] dx, dy, xo, yo, lx, ly;
  logic [2:0] col, row;
  logic on, border, frame_start, blink;
  logic [15:0] frame_cnt;
  sq_t sq, from_q, to_q, ram_sq;
  logic [3:0] promo_q, piece_q, rd_pix, rd_mv, ram_piece;
  logic ram_we, ram_clr;
  assign dx = DrawX - 10'(BOARD_X0);
  assign dy = DrawY - 10'(BOARD_Y0);
  assign on = DrawX >= 10'(BOARD_X0) && DrawX < 10'(BOARD_X0 + BOARD_PX) &&
              DrawY >= 10'(BOARD_Y0) && DrawY < 10'(BOARD_Y0 + BOARD_PX);
  // column/row found by comparing against the fixed square boundaries instead of dividing
  always_comb begin
    col = '0;
    row = '0;
    xo = '0;
    yo = '0;
    for (int k = 1; k < BOARD_SQ; k++) begin
      if (dx >= 10'(k * SQ_SIZE)) begin
        col = 3'(k);
        xo = 10'(k * SQ_SIZE);
      end
      if (dy >= 10'(k * SQ_SIZE)) begin
        row = 3'(k);
        yo = 10'(k * SQ_SIZE);
      end
    end
  end
  assign lx = dx - xo;
  assign ly = dy - yo;
  assign border = lx <= 10'd2 || lx >= 10'(SQ_SIZE - 3) || ly <= 10'd2 || ly >= 10'(SQ_SIZE - 3);
  assign sq = {row, col};
  assign offsetX = on ? 10'(BOARD_X0) + xo : '0;
  assign offsetY = on ? 10'(BOARD_Y0) + yo : '0;
  board_state_ram u_ram (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .pix_sq   (sq),
    .pix_piece(rd_pix),
    .mv_sq    (from_q),
    .mv_piece (rd_mv),
    .wr_en    (ram_we),
    .wr_sq    (ram_sq),
    .wr_piece (ram_piece),
    .clr_en   (ram_clr),
    .clr_sq   (from_q)
  );
  // pixel attributes registered once so they line up with the sprite RGB
  always_ff @(posedge vga_clk)
    if (reset) begin
      pix_square_on <= 1'b0;
      pix_piece <= EMPTY;
      pix_light <= 1'b0;
      pix_cursor <= 1'b0;
      pix_sel <= 1'b0;
    end else begin
      pix_square_on <= on;
      pix_piece <= on ? rd_pix : EMPTY;
      pix_light <= on && !(row[0] ^ col[0]);
      pix_cursor <= on && blink && sq == cursor_sq && border;
      pix_sel <= on && sel_valid && sq == sel_sq;
    end
  assign frame_start = DrawX == '0 && DrawY == '0;
  // cursor blink flips every BLINK_FRAMES frame starts
  always_ff @(posedge vga_clk)
    if (reset) begin
      blink <= 1'b1;
      frame_cnt <= '0;
    end else if (frame_start) begin
      blink <= (frame_cnt == 16'(BLINK_FRAMES - 1)) ? !blink : blink;
      frame_cnt <= (frame_cnt == 16'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + 16'd1;
    end
  // move FSM state register
  always_ff @(posedge vga_clk)
    state <= reset ? IDLE : state_nxt;
  // move FSM next state and board write steering; direct writes only get the port while idle
  always_comb begin
    mv_ready = state == IDLE;
    state_nxt = state == IDLE ? (mv_valid ? READ : IDLE) : state == READ ? WRITE : IDLE;
    ram_we = state == WRITE || (state == IDLE && wr_en);
    ram_clr = state == WRITE;
    ram_sq = state == WRITE ? to_q : wr_sq;
    ram_piece = state == WRITE ? (promo_q != EMPTY ? promo_q : piece_q) : wr_piece;
  end
  // latch the move on accept, then capture the moving piece during READ
  always_ff @(posedge vga_clk)
    if (reset) begin
      from_q <= '0;
      to_q <= '0;
      promo_q <= EMPTY;
      piece_q <= EMPTY;
    end else if (mv_valid && mv_ready) begin
      from_q <= mv_from;
      to_q <= mv_to;
      promo_q <= mv_promo;
    end else if (state == READ) piece_q <= rd_mv;
endmodule

// File: tb/tb_board_sprite_sel.sv
// tb_board_sprite_sel: randomized and directed checks against a behavioural board model
module tb_board_sprite_sel;
  localparam int X0 = 100, Y0 = 20, SQ = 55, BF = 2;
  logic vga_clk = 0, reset = 1;
  logic [9:0] DrawX = 500, DrawY = 500;
  logic mv_valid = 0, wr_en = 0, sel_valid = 0;
  logic [5:0] mv_from = 0, mv_to = 0, wr_sq = 0, cursor_sq = 63, sel_sq = 0;
  logic [3:0] mv_promo = 0, wr_piece = 0;
  logic mv_ready, pix_square_on, pix_light, pix_cursor, pix_sel;
  logic [9:0] offsetX, offsetY;
  logic [3:0] pix_piece;
  int checks = 0, errors = 0;
  int mboard[64];
  int mcd, mfrom, mto, mpromo, mpiece, mcnt, mblink;
  int e_piece, e_on, e_light, e_cur, e_sel;

  always #5 vga_clk = ~vga_clk;

  board_sprite_sel #(.BOARD_X0(X0), .BOARD_Y0(Y0), .BLINK_FRAMES(BF)) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to), .mv_promo(mv_promo),
    .wr_en(wr_en), .wr_sq(wr_sq), .wr_piece(wr_piece),
    .cursor_sq(cursor_sq), .sel_sq(sel_sq), .sel_valid(sel_valid),
    .offsetX(offsetX), .offsetY(offsetY), .pix_piece(pix_piece), .pix_square_on(pix_square_on),
    .pix_light(pix_light), .pix_cursor(pix_cursor), .pix_sel(pix_sel)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int layout(input int s);
    int black[8] = '{12, 10, 11, 13, 14, 11, 10, 12};
    int white[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    int r = s / 8;
    return r == 0 ? black[s % 8] : r == 1 ? 9 : r == 6 ? 1 : r == 7 ? white[s % 8] : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mboard[i] = layout(i);
    mcd = 0;
    mblink = 1;
    mcnt = 0;
  endtask

  task automatic step();
    int x, y, on, s, lx, ly;
    #1;
    x = DrawX;
    y = DrawY;
    on = (x >= X0 && x < X0 + 8 * SQ && y >= Y0 && y < Y0 + 8 * SQ) ? 1 : 0;
    s = on ? ((y - Y0) / SQ) * 8 + (x - X0) / SQ : 0;
    lx = (x - X0) % SQ;
    ly = (y - Y0) % SQ;
    check("offsetX", offsetX, on ? X0 + ((x - X0) / SQ) * SQ : 0);
    check("offsetY", offsetY, on ? Y0 + ((y - Y0) / SQ) * SQ : 0);
    check("mv_ready", mv_ready, mcd == 0 ? 1 : 0);
    if (reset) begin
      {e_piece, e_on, e_light, e_cur, e_sel} = '0;
      model_reset();
    end else begin
      e_on = on;
      e_piece = on ? mboard[s] : 0;
      e_light = (on && ((s / 8) % 2 == (s % 8) % 2)) ? 1 : 0;
      e_cur = (on && mblink && s == cursor_sq && (lx <= 2 || lx >= SQ - 3 || ly <= 2 || ly >= SQ - 3)) ? 1 : 0;
      e_sel = (on && sel_valid && s == sel_sq) ? 1 : 0;
      if (mcd == 0) begin
        if (wr_en) mboard[wr_sq] = wr_piece;
        if (mv_valid) begin
          mfrom = mv_from;
          mto = mv_to;
          mpromo = mv_promo;
          mcd = 2;
        end
      end else if (mcd == 2) begin
        mpiece = mboard[mfrom];
        mcd = 1;
      end else begin
        mboard[mfrom] = 0;
        mboard[mto] = mpromo != 0 ? mpromo : mpiece;
        mcd = 0;
      end
      if (x == 0 && y == 0) begin
        mcnt++;
        if (mcnt == BF) begin
          mblink = 1 - mblink;
          mcnt = 0;
        end
      end
    end
    @(posedge vga_clk);
    #1;
    check("pix_piece", pix_piece, e_piece);
    check("pix_square_on", pix_square_on, e_on);
    check("pix_light", pix_light, e_light);
    check("pix_cursor", pix_cursor, e_cur);
    check("pix_sel", pix_sel, e_sel);
  endtask

  task automatic at(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
  endtask

  task automatic at_sq(input int s);
    at(X0 + (s % 8) * SQ + 27, Y0 + (s / 8) * SQ + 27);
  endtask

  task automatic move(input int f, input int t, input int p);
    mv_valid = 1;
    mv_from = 6'(f);
    mv_to = 6'(t);
    mv_promo = 4'(p);
    step();
    mv_valid = 0;
    mv_promo = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cs;
    @(posedge vga_clk);
    #1;
    model_reset();
    step();
    reset = 0;
    DrawX = X0 + 1;
    DrawY = Y0 + 1;
    #1;
    check("reset_offsetX", offsetX, 100);
    check("reset_offsetY", offsetY, 20);
    step();
    check("reset_piece", pix_piece, 12);
    check("reset_light", pix_light, 1);
    DrawX = 154;
    #1;
    check("edge154_offsetX", offsetX, 100);
    step();
    check("edge154_light", pix_light, 1);
    DrawX = 155;
    #1;
    check("edge155_offsetX", offsetX, 155);
    step();
    check("edge155_light", pix_light, 0);
    move(52, 36, 0);
    check("move_ready_read", mv_ready, 0);
    step();
    check("move_ready_write", mv_ready, 0);
    step();
    check("move_ready_back", mv_ready, 1);
    at_sq(52);
    check("move_from_empty", pix_piece, 0);
    at_sq(36);
    check("move_to_pawn", pix_piece, 1);
    move(8, 0, 5);
    step();
    step();
    at_sq(0);
    check("promo_to", pix_piece, 5);
    at_sq(8);
    check("promo_from", pix_piece, 0);
    wr_en = 1;
    wr_sq = 57;
    wr_piece = 5;
    move(57, 42, 0);
    wr_en = 0;
    step();
    step();
    at_sq(42);
    check("wr_accept_to", pix_piece, 5);
    at_sq(57);
    check("wr_accept_from", pix_piece, 0);
    move(10, 18, 0);
    wr_en = 1;
    wr_sq = 30;
    wr_piece = 7;
    step();
    wr_en = 0;
    step();
    at_sq(30);
    check("wr_blocked", pix_piece, 0);
    at_sq(18);
    check("blocked_move_to", pix_piece, 9);
    move(35, 35, 0);
    step();
    step();
    at_sq(35);
    check("same_square", pix_piece, 0);
    move(51, 35, 0);
    reset = 1;
    step();
    reset = 0;
    check("midmove_ready", mv_ready, 1);
    at_sq(52);
    check("midmove_layout52", pix_piece, 1);
    at_sq(35);
    check("midmove_layout35", pix_piece, 0);
    at_sq(51);
    check("midmove_layout51", pix_piece, 1);
    cursor_sq = 0;
    at(X0, Y0);
    check("cursor_corner", pix_cursor, 1);
    at(X0 + 27, Y0 + 27);
    check("cursor_centre", pix_cursor, 0);
    at(X0 + 52, Y0 + 27);
    check("cursor_edge52", pix_cursor, 1);
    at(X0 + 51, Y0 + 27);
    check("cursor_inner51", pix_cursor, 0);
    at(0, 0);
    at(X0 + 1, Y0 + 1);
    check("cursor_one_frame", pix_cursor, 1);
    at(0, 0);
    at(X0 + 1, Y0 + 1);
    check("cursor_blink_off", pix_cursor, 0);
    sel_valid = 1;
    sel_sq = 36;
    at_sq(36);
    check("sel_on", pix_sel, 1);
    sel_sq = 0;
    DrawX = 50;
    DrawY = 100;
    #1;
    check("off_offsetX", offsetX, 0);
    check("off_offsetY", offsetY, 0);
    step();
    check("off_on", pix_square_on, 0);
    check("off_piece", pix_piece, 0);
    check("off_light", pix_light, 0);
    check("off_sel", pix_sel, 0);
    for (int i = 0; i < 3000; i++) begin
      cs = $urandom_range(0, 63);
      cursor_sq = 6'(cs);
      sel_sq = $urandom_range(0, 1) ? 6'(cs) : 6'($urandom_range(0, 63));
      sel_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        DrawX = 0;
        DrawY = 0;
      end else if ($urandom_range(0, 1)) begin
        DrawX = 10'(X0 + (cs % 8) * SQ + $urandom_range(0, SQ - 1));
        DrawY = 10'(Y0 + (cs / 8) * SQ + $urandom_range(0, SQ - 1));
      end else begin
        DrawX = 10'($urandom_range(0, 639));
        DrawY = 10'($urandom_range(0, 479));
      end
      mv_valid = ($urandom_range(0, 7) == 0);
      mv_from = 6'($urandom_range(0, 63));
      mv_to = $urandom_range(0, 7) == 0 ? mv_from : 6'($urandom_range(0, 63));
      mv_promo = $urandom_range(0, 3) == 0 ? 4'($urandom_range(1, 14)) : 4'd0;
      wr_en = ($urandom_range(0, 9) == 0);
      wr_sq = 6'($urandom_range(0, 63));
      wr_piece = 4'($urandom_range(0, 14));
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0;
    mv_valid = 0;
    wr_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
